// File: rtl/rst_seq.sv
// rst_seq: staged per-subsystem reset sequencer driven by PLL lock and a 1 kHz tick.
// Define RSTSEQ_WDOG_EN to add a tick watchdog that injects synthetic ticks.
module rst_seq #(
    parameter int pStages     = 4,
    parameter int pHoldMs     = 10,
    parameter int pStageGapMs = 1,
    parameter int pLossFilt   = 4,
    parameter int pWdogCycles = 200000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               locked_i,
    input  logic               pulse1000Hz_i,
    input  logic               sw_reset_i,
    output logic [pStages-1:0] rst_o,
    output logic               ready_o,
    output logic [1:0]         state_o,
    output logic [7:0]         loss_cnt_o,
    output logic               tick_err_o
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int KW = $clog2(pStages + 1);
    localparam logic [pStages-1:0] ONES = {pStages{1'b1}};
    localparam logic [pStages-1:0] ONE  = pStages'(1);

    if (pStages < 1 || pStages > 8 || pHoldMs < 1 || pHoldMs > 255 ||
        pStageGapMs < 1 || pStageGapMs > 255 || pLossFilt < 1 || pLossFilt > 15 ||
        pWdogCycles < 2) begin : g_param_check
        $error("rst_seq: parameter out of range");
    end

    logic               lock_s1_q, lock_s2_q;
    logic               pulse_s1_q, pulse_s2_q, pulse_prev_q;
    logic [3:0]         lfilt_q, lfilt_d;
    state_t             state_q, state_d;
    logic [7:0]         ms_q, ms_d;
    logic [7:0]         loss_cnt_q, loss_cnt_d;
    logic [KW-1:0]      k_q, k_d;
    logic [pStages-1:0] rst_q, rst_d;
    logic               ready_q, ready_d;
    logic               tick_s, loss_s, eff_tick_s;

    assign tick_s = pulse_s2_q & ~pulse_prev_q;
    // Fires once per low run: the cycle the filter count steps onto pLossFilt.
    assign loss_s = ~lock_s2_q & (lfilt_q == 4'(pLossFilt - 1));

    // Lock-loss filter: counts synced-low cycles, saturating at pLossFilt.
    always_comb begin
        lfilt_d = lfilt_q;
        if (lock_s2_q) begin
            lfilt_d = 4'd0;
        end else if (lfilt_q != 4'(pLossFilt)) begin
            lfilt_d = lfilt_q + 4'd1;
        end else begin
            lfilt_d = lfilt_q;
        end
    end

`ifdef RSTSEQ_WDOG_EN
    localparam int WW = $clog2(pWdogCycles + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          wdog_fire_s, in_seq_s, tick_err_q;

    // Watchdog: counts clk cycles between ticks while sequencing.
    always_comb begin
        in_seq_s    = (state_q == HOLD) || (state_q == RELEASE);
        wdog_fire_s = in_seq_s & ~tick_s & (wdog_q == WW'(pWdogCycles - 1));
        if (!in_seq_s || tick_s || wdog_fire_s) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q     <= '0;
            tick_err_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            tick_err_q <= tick_err_q | wdog_fire_s;
        end
    end

    assign eff_tick_s = tick_s | wdog_fire_s;
    assign tick_err_o = tick_err_q;
`else
    assign eff_tick_s = tick_s;
    assign tick_err_o = 1'b0;
`endif

    // Next state and next outputs; loss beats software reset beats tick.
    always_comb begin
        state_d    = state_q;
        ms_d       = ms_q;
        k_d        = k_q;
        rst_d      = rst_q;
        loss_cnt_d = loss_cnt_q;
        if (loss_s && (state_q != WAIT_LOCK)) begin
            state_d    = WAIT_LOCK;
            rst_d      = ONES;
            ms_d       = 8'd0;
            loss_cnt_d = (loss_cnt_q == 8'hFF) ? loss_cnt_q : loss_cnt_q + 8'd1;
        end else if (sw_reset_i && ((state_q == RELEASE) || (state_q == RUN))) begin
            state_d = HOLD;
            rst_d   = ONES;
            ms_d    = 8'd0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    rst_d = ONES;
                    ms_d  = 8'd0;
                    if (lock_s2_q) begin
                        state_d = HOLD;
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
                HOLD: begin
                    if (!eff_tick_s) begin
                        ms_d = ms_q;
                    end else if (ms_q + 8'd1 == 8'(pHoldMs)) begin
                        rst_d   = rst_q & ~ONE;
                        ms_d    = 8'd0;
                        k_d     = KW'(1);
                        state_d = (pStages == 1) ? RUN : RELEASE;
                    end else begin
                        ms_d = ms_q + 8'd1;
                    end
                end
                RELEASE: begin
                    if (!eff_tick_s) begin
                        ms_d = ms_q;
                    end else if (ms_q + 8'd1 == 8'(pStageGapMs)) begin
                        rst_d = rst_q & ~(ONE << k_q);
                        ms_d  = 8'd0;
                        if (k_q == KW'(pStages - 1)) begin
                            state_d = RUN;
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end else begin
                        ms_d = ms_q + 8'd1;
                    end
                end
                RUN: begin
                    rst_d = '0;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    rst_d   = ONES;
                end
            endcase
        end
        ready_d = (state_d == RUN);
    end

    // Synchronisers, filter, FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_s1_q    <= 1'b0;
            lock_s2_q    <= 1'b0;
            pulse_s1_q   <= 1'b0;
            pulse_s2_q   <= 1'b0;
            pulse_prev_q <= 1'b0;
            lfilt_q      <= 4'd0;
            state_q      <= WAIT_LOCK;
            ms_q         <= 8'd0;
            k_q          <= '0;
            rst_q        <= ONES;
            ready_q      <= 1'b0;
            loss_cnt_q   <= 8'd0;
        end else begin
            lock_s1_q    <= locked_i;
            lock_s2_q    <= lock_s1_q;
            pulse_s1_q   <= pulse1000Hz_i;
            pulse_s2_q   <= pulse_s1_q;
            pulse_prev_q <= pulse_s2_q;
            lfilt_q      <= lfilt_d;
            state_q      <= state_d;
            ms_q         <= ms_d;
            k_q          <= k_d;
            rst_q        <= rst_d;
            ready_q      <= ready_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    assign rst_o      = rst_q;
    assign ready_o    = ready_q;
    assign state_o    = state_q;
    assign loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: a tick-count model predicts each output change.
module tb_rst_seq;
    localparam int NST = 4, HOLD_MS = 3, GAP_MS = 1, FILT = 4, WDOG = 50;

    logic           clk, rst, locked_i, pulse_i, sw_i;
    logic [NST-1:0] rst_o;
    logic           ready_o, tick_err_o;
    logic [1:0]     state_o;
    logic [7:0]     loss_cnt_o;

    rst_seq #(.pStages(NST), .pHoldMs(HOLD_MS), .pStageGapMs(GAP_MS),
              .pLossFilt(FILT), .pWdogCycles(WDOG)) dut (
        .clk(clk), .rst(rst), .locked_i(locked_i), .pulse1000Hz_i(pulse_i),
        .sw_reset_i(sw_i), .rst_o(rst_o), .ready_o(ready_o), .state_o(state_o),
        .loss_cnt_o(loss_cnt_o), .tick_err_o(tick_err_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    bit m_wait = 1'b1;
    int m_ticks = 0, m_cnt = 0;
    bit m_err = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_last, seen;
    bit mon_en = 1'b0;

    function automatic logic [15:0] pack(input logic [3:0] r, input logic rd,
                                         input logic [1:0] st, input logic [7:0] c, input logic e);
        return {r, rd, st, c, e};
    endfunction

    // Stages released so far: stage i goes at tick HOLD_MS + i*GAP_MS after HOLD entry.
    function automatic int released();
        int n = 0;
        if (m_wait) return 0;
        for (int i = 0; i < NST; i++) if (m_ticks >= HOLD_MS + i * GAP_MS) n++;
        return n;
    endfunction

    function automatic logic [15:0] model_snap();
        logic [3:0] r;
        logic [1:0] st;
        int n;
        n = released();
        r = 4'b1111 << n;
        if (m_wait) st = 2'd0;
        else if (n == 0) st = 2'd1;
        else if (n == NST) st = 2'd3;
        else st = 2'd2;
        return pack(r, st == 2'd3, st, m_cnt[7:0], m_err);
    endfunction

    task automatic model_push();
        logic [15:0] s;
        s = model_snap();
        if (s !== exp_last) begin
            exp_q.push_back(s);
            exp_last = s;
        end
    endtask

    function automatic logic [15:0] dut_snap();
        return pack(rst_o, ready_o, state_o, loss_cnt_o, tick_err_o);
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every change of the DUT outputs must match the next predicted snapshot.
    always @(negedge clk) begin
        if (mon_en && (dut_snap() !== seen)) begin
            seen = dut_snap();
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_change: got %h want none", seen);
            end else begin
                check("out_change", seen, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic op_lock();
        m_wait = 1'b0; m_ticks = 0; model_push();
        locked_i = 1'b1; cyc(6);
    endtask

    task automatic op_tick();
        if (!m_wait) begin m_ticks++; model_push(); end
        pulse_i = 1'b1; cyc(4);
        pulse_i = 1'b0; cyc(4);
    endtask

    task automatic model_loss();
        if (!m_wait) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_wait = 1'b1;
            model_push();
        end
    endtask

    task automatic op_loss();
        model_loss();
        locked_i = 1'b0; cyc(8);
    endtask

    task automatic op_glitch(input int n);
        locked_i = 1'b0; cyc(n);
        locked_i = 1'b1; cyc(6);
    endtask

    task automatic op_sw();
        if (released() >= 1) begin m_ticks = 0; model_push(); end
        sw_i = 1'b1; cyc(1);
        sw_i = 1'b0; cyc(2);
    endtask

    // Lock drop timed so the loss event and sw_reset_i hit the same edge.
    task automatic op_loss_sw();
        model_loss();
        locked_i = 1'b0; cyc(5);
        sw_i = 1'b1; cyc(1);
        sw_i = 1'b0; cyc(4);
    endtask

    task automatic sample_check(input string name, input logic [15:0] want);
        @(negedge clk);
        check(name, dut_snap(), want);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; locked_i = 1'b0; pulse_i = 1'b0; sw_i = 1'b0;
        cyc(4);
        sample_check("reset", pack(4'hF, 1'b0, 2'd0, 8'd0, 1'b0));
        seen = pack(4'hF, 1'b0, 2'd0, 8'd0, 1'b0);
        exp_last = seen;
        mon_en = 1'b1;
        rst = 1'b0; cyc(2);

        op_lock();
        repeat (6) op_tick();
        sample_check("first_run", pack(4'h0, 1'b1, 2'd3, 8'd0, 1'b0));

        op_glitch(3);
        sample_check("glitch3", pack(4'h0, 1'b1, 2'd3, 8'd0, 1'b0));
        op_loss();
        sample_check("loss", pack(4'hF, 1'b0, 2'd0, 8'd1, 1'b0));
        op_lock();
        repeat (6) op_tick();

        op_sw();
        sample_check("sw_in_run", pack(4'hF, 1'b0, 2'd1, 8'd1, 1'b0));
        repeat (6) op_tick();

        op_sw();
        repeat (4) op_tick();
        op_loss_sw();
        sample_check("loss_beats_sw", pack(4'hF, 1'b0, 2'd0, 8'd2, 1'b0));

`ifndef RSTSEQ_WDOG_EN
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_wait) op_lock();
            else if (r < 45) op_tick();
            else if (r < 55) op_glitch($urandom_range(1, 3));
            else if (r < 65) op_loss();
            else if (r < 85) op_sw();
            else if (released() >= 1 && released() < NST) op_loss_sw();
            else op_tick();
        end
`endif

        for (int i = 0; i < 300; i++) begin
            if (m_wait) op_lock();
            op_loss();
        end
        sample_check("loss_saturate", pack(4'hF, 1'b0, 2'd0, 8'd255, 1'b0));

        op_lock();
`ifdef RSTSEQ_WDOG_EN
        while (released() < NST) begin
            m_err = 1'b1; m_ticks++; model_push();
        end
        cyc(600);
        sample_check("wdog_completes", pack(4'h0, 1'b1, 2'd3, 8'd255, 1'b1));
`else
        cyc(600);
        sample_check("no_tick_stuck", pack(4'hF, 1'b0, 2'd1, 8'd255, 1'b0));
`endif

        cyc(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
